// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    MATCH  = 1'b1
  } state_e;

  localparam logic [3:0] RST_PAT = 4'b1010;
  localparam int         RST_LEN = 4;

endpackage

// File: rtl/seq_det_prefix_match.sv
// Combinational compare of the sample history against the active pattern.
// Reports a full L-bit match and the longest proper pattern prefix ending at the newest sample.
module seq_det_prefix_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist_i,
  input  logic [LEN_W-1:0]   depth_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               full_match_o,
  output logic [LEN_W-1:0]   progress_o
);

  localparam logic [MAX_LEN-1:0] ONES = '1;

  logic [MAX_LEN-1:0] len_mask;

  // The first k pattern bits sit at pat[L-1:L-k]; shifting them down aligns them with hist[k-1:0].
  always_comb begin
    full_match_o = 1'b0;
    progress_o   = '0;
    len_mask     = ONES >> (MAX_LEN - int'(len_i));
    if (len_i != '0 && depth_i >= len_i && ((hist_i ^ pat_i) & len_mask) == '0)
      full_match_o = 1'b1;
    for (int k = 1; k < MAX_LEN; k++) begin
      if (k < int'(len_i) && k <= int'(depth_i)) begin
        if (((hist_i ^ (pat_i >> (int'(len_i) - k))) & (ONES >> (MAX_LEN - k))) == '0)
          progress_o = LEN_W'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector: Moore flag z, match strobe, saturating counter.
// Outputs are registered one edge after the accepted sample; x_valid low freezes all state.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   progress
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   depth_q, depth_d;
  logic [LEN_W-1:0]   prog_q, prog_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_eff;
  logic [MAX_LEN-1:0] samp_hist;
  logic [LEN_W-1:0]   samp_depth;
  logic [LEN_W-1:0]   samp_prog;
  logic               full_match;

  assign len_eff    = (len_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q;
  assign samp_hist  = {hist_q[MAX_LEN-2:0], x};
  assign samp_depth = (depth_q == LEN_W'(MAX_LEN)) ? depth_q : depth_q + LEN_W'(1);

  // Evaluated on the would-be history so the match is decided in the same cycle the bit arrives.
  seq_det_prefix_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_prefix_match (
    .hist_i       (samp_hist),
    .depth_i      (samp_depth),
    .pat_i        (pat_q),
    .len_i        (len_eff),
    .full_match_o (full_match),
    .progress_o   (samp_prog)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      pat_q   <= MAX_LEN'(RST_PAT);
      len_q   <= LEN_W'(RST_LEN);
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      depth_q <= '0;
      prog_q  <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      depth_q <= depth_d;
      prog_q  <= prog_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    depth_d = depth_q;
    prog_d  = prog_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      depth_d = '0;
      prog_d  = '0;
      state_d = SEARCH;
    end else if (x_valid) begin
      hist_d  = samp_hist;
      depth_d = samp_depth;
      prog_d  = samp_prog;
      case (state_q)
        SEARCH:  if (full_match) state_d = MATCH;
        MATCH:   if (!full_match) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
      if (full_match) begin
        pulse_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // Non-overlapping: forget the bits just consumed by this match.
        if (!ovl_q) begin
          depth_d = '0;
          prog_d  = '0;
        end
      end
    end
    if (cnt_clr) cnt_d = '0;
  end

  assign z           = (state_q == MATCH);
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign progress    = prog_q;

endmodule
